// File: rtl/mem_target.sv
// mem_target: single-word-per-transaction bus target with a 32-bit
// multiplexed AD bus and an active-low TRDY_B handshake.
// Claims word addresses BASE_ADDR .. BASE_ADDR+DEPTH-1, inserts WAIT_STATES
// wait cycles, then acknowledges for one cycle before a turnaround cycle.
// Optional macro MEM_TARGET_WPROT_EN write-protects offsets 0..15. Protected
// writes still complete the handshake but leave memory unchanged.
module mem_target #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          DEPTH       = 256,
    parameter int          WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        RST_B,
    input  logic        FRAME_B,
    input  logic        CMD,
    input  logic        IRDY_B,
    inout  wire  [31:0] AD,
    output wire         TRDY_B
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        ACK    = 3'd2,
        TURN   = 3'd3,
        IGNORE = 3'd4
    } state_t;

    state_t          state, next_state;
    logic [3:0]      cnt;
    logic [31:0]     addr;
    logic            cmdl;
    logic [31:0]     rd_data;
    logic [31:0]     mem [DEPTH];

    logic            frame_act;
    logic            irdy_act;
    logic            in_range;
    logic [AW-1:0]   off;
    logic            ack_go;
    logic            wp_ok;
    logic            mem_we;

    // An X/Z on FRAME_B or IRDY_B evaluates false in every if() below,
    // so only a clean 0 counts as asserted.
    assign frame_act = (FRAME_B == 1'b0);
    assign irdy_act  = (IRDY_B == 1'b0);

    // Range check avoids BASE_ADDR+DEPTH overflow by comparing the offset.
    assign in_range = (AD >= BASE_ADDR) && ((AD - BASE_ADDR) < 32'(DEPTH));

    // Offset is only used after the range check, so truncation cannot wrap.
    assign off = AW'(addr - BASE_ADDR);

    // Data phase completes when the wait count is spent, the initiator is
    // ready and the frame is still held (a released frame is an abort).
    assign ack_go = (state == WAIT) && frame_act && (cnt == 4'd0) && irdy_act;

`ifdef MEM_TARGET_WPROT_EN
    assign wp_ok = (32'(off) >= 32'd16);
`else
    assign wp_ok = 1'b1;
`endif

    assign mem_we = ack_go && cmdl && wp_ok;

    // State, address/command latch, wait counter and read data capture.
    always_ff @(posedge CLK) begin
        if (!RST_B) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr    <= 32'd0;
            cmdl    <= 1'b0;
            rd_data <= 32'd0;
        end else begin
            state <= next_state;
            if (state == IDLE && frame_act) begin
                addr <= AD;
                cmdl <= CMD;
                cnt  <= 4'(WAIT_STATES);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (ack_go && !cmdl)
                rd_data <= mem[off];
        end
    end

    // Storage is never cleared; a write is blocked while reset is sampled low.
    always_ff @(posedge CLK) begin
        if (RST_B && mem_we)
            mem[off] <= AD;
    end

    // Next-state logic; default is to hold.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (frame_act)
                    next_state = in_range ? WAIT : IGNORE;
            end
            WAIT: begin
                next_state = IDLE;
                if (frame_act)
                    next_state = ack_go ? ACK : WAIT;
            end
            ACK: begin
                next_state = TURN;
            end
            TURN: begin
                next_state = IDLE;
                if (frame_act)
                    next_state = TURN;
            end
            IGNORE: begin
                next_state = IDLE;
                if (frame_act)
                    next_state = IGNORE;
            end
            default: next_state = IDLE;
        endcase
    end

    // TRDY_B: low in ACK, high in TURN, released otherwise.
    assign TRDY_B = (state == ACK)  ? 1'b0 :
                    (state == TURN) ? 1'b1 : 1'bz;

    // AD is driven only during the ACK cycle of a read.
    assign AD = (state == ACK && !cmdl) ? rd_data : 32'bz;

endmodule

// File: tb/tb_mem_target.sv
// Directed bench for mem_target (default parameters). Pull-ups on AD and
// TRDY_B make a released bus read back as all ones.
module tb_mem_target;

    logic        CLK = 1'b0;
    logic        RST_B;
    logic        FRAME_B;
    logic        CMD;
    logic        IRDY_B;
    wire  [31:0] AD;
    wire         TRDY_B;

    logic [31:0] tb_ad;
    logic        tb_oe;

    int n_cmp = 0;
    int n_err = 0;

    assign AD = tb_oe ? tb_ad : 32'bz;
    pullup (AD);
    pullup (TRDY_B);

    mem_target dut (
        .CLK    (CLK),
        .RST_B  (RST_B),
        .FRAME_B(FRAME_B),
        .CMD    (CMD),
        .IRDY_B (IRDY_B),
        .AD     (AD),
        .TRDY_B (TRDY_B)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One transaction. lat = edges from the address edge to TRDY_B low
    // (-1 if never within 20 edges). drv flags AD seen driven on a read
    // outside the ACK cycle. Inputs change only at negedges.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input int irdy_dly, output logic [31:0] rd, output int lat,
                        output logic drv);
        int e;
        lat = -1;
        drv = 1'b0;
        rd  = 32'd0;
        @(negedge CLK);
        FRAME_B = 1'b0; CMD = wr; tb_ad = a; tb_oe = 1'b1; IRDY_B = 1'b1;
        @(negedge CLK);
        tb_ad = wd; tb_oe = wr;
        if (irdy_dly == 0) IRDY_B = 1'b0;
        e = 1;
        while (e <= 20 && lat < 0) begin
            @(negedge CLK);
            if (TRDY_B === 1'b0) begin
                lat = e;
                rd  = AD;
            end else if (!wr && AD !== 32'hFFFF_FFFF) begin
                drv = 1'b1;
            end
            if (e == irdy_dly) IRDY_B = 1'b0;
            e++;
        end
        if (lat >= 0) begin
            @(negedge CLK);
            chk("trdy_one_cycle", {31'd0, TRDY_B}, 32'd1);
            if (!wr) chk("ad_released_turn", AD, 32'hFFFF_FFFF);
        end
        FRAME_B = 1'b1; IRDY_B = 1'b1; tb_oe = 1'b0;
        @(negedge CLK);
    endtask

    logic [31:0] rd;
    logic [31:0] prior;
    int          lat;
    logic        drv;
    logic        seen;

    initial begin
        RST_B = 1'b0; FRAME_B = 1'b1; CMD = 1'b0; IRDY_B = 1'b1;
        tb_ad = 32'd0; tb_oe = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_trdy_z", {31'd0, TRDY_B}, 32'd1);
        chk("reset_ad_z", AD, 32'hFFFF_FFFF);
        RST_B = 1'b1;
        @(negedge CLK);

        // Write then read back; latency WAIT_STATES+1 = 3 edges.
        xfer(1'b1, 32'h1020, 32'hDEAD_BEEF, 0, rd, lat, drv);
        chk("wr1020_lat", 32'(lat), 32'd3);
        xfer(1'b0, 32'h1020, 32'h0, 0, rd, lat, drv);
        chk("rd1020_lat", 32'(lat), 32'd3);
        chk("rd1020_data", rd, 32'hDEAD_BEEF);
        chk("rd1020_nodrv", {31'd0, drv}, 32'd0);

        // Last word of the window.
        xfer(1'b1, 32'h10FF, 32'hCAFE_F00D, 0, rd, lat, drv);
        chk("wr10ff_lat", 32'(lat), 32'd3);
        xfer(1'b0, 32'h10FF, 32'h0, 0, rd, lat, drv);
        chk("rd10ff_data", rd, 32'hCAFE_F00D);

`ifndef MEM_TARGET_WPROT_EN
        // First word of the window.
        xfer(1'b1, 32'h1000, 32'h0123_4567, 0, rd, lat, drv);
        xfer(1'b0, 32'h1000, 32'h0, 0, rd, lat, drv);
        chk("rd1000_data", rd, 32'h0123_4567);
`endif

        // IRDY_B late: raised-high through 5 edges, ACK on edge 6.
        xfer(1'b0, 32'h1020, 32'h0, 5, rd, lat, drv);
        chk("late_irdy_lat", 32'(lat), 32'd6);
        chk("late_irdy_data", rd, 32'hDEAD_BEEF);

        // Out of range both sides: never acknowledged, AD never driven.
        xfer(1'b0, 32'h0FFF, 32'h0, 0, rd, lat, drv);
        chk("oor_0fff_lat", 32'(lat), 32'hFFFF_FFFF);
        chk("oor_0fff_nodrv", {31'd0, drv}, 32'd0);
        xfer(1'b0, 32'h1100, 32'h0, 0, rd, lat, drv);
        chk("oor_1100_lat", 32'(lat), 32'hFFFF_FFFF);
        chk("oor_1100_nodrv", {31'd0, drv}, 32'd0);

        // Abort: frame released in WAIT of a write to 0x1005.
        xfer(1'b1, 32'h1005, 32'h1111_1111, 0, rd, lat, drv);
        chk("pre5_lat", 32'(lat), 32'd3);
        seen = 1'b0;
        @(negedge CLK);
        FRAME_B = 1'b0; CMD = 1'b1; tb_ad = 32'h1005; tb_oe = 1'b1; IRDY_B = 1'b1;
        @(negedge CLK);
        tb_ad = 32'h0000_0BAD;
        @(negedge CLK);
        FRAME_B = 1'b1; IRDY_B = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (TRDY_B === 1'b0) seen = 1'b1;
        end
        chk("abort_no_trdy", {31'd0, seen}, 32'd0);
        IRDY_B = 1'b1; tb_oe = 1'b0;
        xfer(1'b0, 32'h1005, 32'h0, 0, rd, lat, drv);
        chk("abort_next_lat", 32'(lat), 32'd3);
        chk("abort_mem5", rd, 32'h1111_1111);

        // Reset mid-WAIT of a write to 0x1008, held across the would-be ACK.
        xfer(1'b1, 32'h1008, 32'h8888_8888, 0, rd, lat, drv);
        seen = 1'b0;
        @(negedge CLK);
        FRAME_B = 1'b0; CMD = 1'b1; tb_ad = 32'h1008; tb_oe = 1'b1; IRDY_B = 1'b1;
        @(negedge CLK);
        tb_ad = 32'h0BAD_0008; IRDY_B = 1'b0;
        @(negedge CLK);
        RST_B = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (TRDY_B === 1'b0) seen = 1'b1;
        end
        chk("rst_no_trdy", {31'd0, seen}, 32'd0);
        chk("rst_trdy_z", {31'd0, TRDY_B}, 32'd1);
        tb_oe = 1'b0; FRAME_B = 1'b1; IRDY_B = 1'b1;
        @(negedge CLK);
        chk("rst_ad_z", AD, 32'hFFFF_FFFF);
        RST_B = 1'b1;
        xfer(1'b0, 32'h1008, 32'h0, 0, rd, lat, drv);
        chk("rst_next_lat", 32'(lat), 32'd3);
        chk("rst_mem8", rd, 32'h8888_8888);

`ifdef MEM_TARGET_WPROT_EN
        xfer(1'b0, 32'h1003, 32'h0, 0, prior, lat, drv);
        xfer(1'b1, 32'h1003, 32'h0000_0055, 0, rd, lat, drv);
        chk("wprot_wr_lat", 32'(lat), 32'd3);
        xfer(1'b0, 32'h1003, 32'h0, 0, rd, lat, drv);
        chk("wprot_rd1003", rd, prior);
        xfer(1'b1, 32'h1010, 32'h0000_0055, 0, rd, lat, drv);
        xfer(1'b0, 32'h1010, 32'h0, 0, rd, lat, drv);
        chk("wprot_rd1010", rd, 32'h0000_0055);
`else
        prior = 32'd0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
